// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex font, segment-off code and the polarity helper.
package seg_pkg;

  // Active-high {g,f,e,d,c,b,a} codes for 0-9, A, b, C, d, E, F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int         DP_BIT  = 7;

  function automatic logic [7:0] apply_pol(input logic [7:0] code, input logic active_low);
    return active_low ? ~code : code;
  endfunction

endpackage

// File: rtl/seg_scan_driver_font.sv
// Combinational hex nibble to active-high 7-segment code.
module hex7seg_font
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_code
);

  assign o_code = HEX_FONT[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-frame snapshot, anti-ghost blanking,
// per-digit DP, digit mask and leading-zero suppression. Outputs are registered (1-cycle latency).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_supp,
  input  logic                      blank,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                seg,
  output logic                      frame_tick
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(SCAN_DIV);

  logic [PRESC_W-1:0]          r_presc;
  logic [IDX_W-1:0]            r_idx;
  logic [4*NUM_DIGITS-1:0]     r_snap_data;
  logic [NUM_DIGITS-1:0]       r_snap_dp;
  logic [NUM_DIGITS-1:0]       r_snap_en;
  logic                        r_snap_lz;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [7:0]                  r_seg;
  logic                        r_frame_tick;

  logic                        w_slot_end;
  logic                        w_take;
  logic [4*NUM_DIGITS-1:0]     w_data;
  logic [NUM_DIGITS-1:0]       w_dp;
  logic [NUM_DIGITS-1:0]       w_en;
  logic                        w_lz;
  logic [NUM_DIGITS-1:0][3:0]  w_nibs;
  logic [6:0]                  w_code;
  logic                        w_hi_zero;
  logic                        w_supp;
  logic                        w_lit;
  logic [NUM_DIGITS-1:0]       w_onehot;
  logic [7:0]                  w_seg_hi;

  assign w_slot_end = (r_presc == PRESC_W'(SCAN_DIV - 1));
  assign w_take     = (r_idx == '0) && (r_presc == '0);

  // On the snapshot clock the live inputs are used directly so digit 0 never shows a stale frame
  assign w_data = w_take ? data     : r_snap_data;
  assign w_dp   = w_take ? dp_en    : r_snap_dp;
  assign w_en   = w_take ? digit_en : r_snap_en;
  assign w_lz   = w_take ? lz_supp  : r_snap_lz;
  assign w_nibs = w_data;

  hex7seg_font u_font (
    .i_nib  (w_nibs[r_idx]),
    .o_code (w_code)
  );

  always_comb begin
    w_hi_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(r_idx) && w_nibs[j] != 4'h0) w_hi_zero = 1'b0;
    end
    w_supp   = w_lz && (r_idx != '0) && w_hi_zero;
    w_lit    = (int'(r_presc) >= BLANK_CYC) && w_en[r_idx] && !blank;
    w_onehot = '0;
    w_onehot[r_idx] = 1'b1;
    w_seg_hi = SEG_OFF;
    w_seg_hi[6:0]  = w_supp ? 7'h00 : w_code;
    w_seg_hi[DP_BIT] = w_dp[r_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_snap_data  <= '0;
      r_snap_dp    <= '0;
      r_snap_en    <= '0;
      r_snap_lz    <= 1'b0;
      r_an         <= AN_ACTIVE_LOW ? '1 : '0;
      r_seg        <= apply_pol(SEG_OFF, SEG_ACTIVE_LOW);
      r_frame_tick <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end) r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (w_take) begin
        r_snap_data <= data;
        r_snap_dp   <= dp_en;
        r_snap_en   <= digit_en;
        r_snap_lz   <= lz_supp;
      end
      r_frame_tick <= w_take;
      if (w_lit) begin
        r_an  <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
        r_seg <= apply_pol(w_seg_hi, SEG_ACTIVE_LOW);
      end else begin
        r_an  <= AN_ACTIVE_LOW ? '1 : '0;
        r_seg <= apply_pol(SEG_OFF, SEG_ACTIVE_LOW);
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 4 clocks/slot, 1 blank clock, active-low pins).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;
  logic        lz_supp;
  logic        blank;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_vec  = 0;
  int n_fail = 0;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dp_en(dp_en), .digit_en(digit_en),
    .lz_supp(lz_supp), .blank(blank), .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state tracking what the display should be doing
  int          m_presc = 0;
  int          m_idx   = 0;
  logic [15:0] m_sd  = '0;
  logic [3:0]  m_sdp = '0;
  logic [3:0]  m_sen = '0;
  logic        m_slz = 1'b0;
  logic [12:0] sb_q [$];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert ($onehot0(~an)) else begin
        n_fail++;
        $error("FAIL onehot: observed an=%b expected at most one active", an);
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic        e_ft;
    logic [7:0]  hi;
    logic        supp;
    logic [12:0] ent;
    e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
    if (rst) begin
      m_presc = 0; m_idx = 0; m_sd = '0; m_sdp = '0; m_sen = '0; m_slz = 1'b0;
    end else begin
      e_ft = (m_idx == 0 && m_presc == 0);
      if (e_ft) begin
        m_sd = data; m_sdp = dp_en; m_sen = digit_en; m_slz = lz_supp;
      end
      supp = m_slz && (m_idx > 0) && ((m_sd >> (4 * m_idx)) == 16'h0);
      hi   = {m_sdp[m_idx], supp ? 7'h00 : font[m_sd[4*m_idx +: 4]]};
      if (m_presc >= 1 && m_sen[m_idx] && !blank) begin
        e_an  = ~(4'b0001 << m_idx);
        e_seg = ~hi;
      end
      if (m_presc == 3) begin
        m_presc = 0;
        m_idx   = (m_idx == 3) ? 0 : m_idx + 1;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    sb_q.push_back({e_an, e_seg, e_ft});
    @(posedge clk);
    #1;
    ent = sb_q.pop_front();
    chk("sb_an",  16'(an),         16'(ent[12:9]));
    chk("sb_seg", 16'(seg),        16'(ent[8:1]));
    chk("sb_ft",  16'(frame_tick), 16'(ent[0]));
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    chk("frame_timeout", 16'(seen), 16'd1);
  endtask

  task automatic expect_digit(input logic [3:0] an_exp, input logic [7:0] seg_exp);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (an === an_exp) seen = 1'b1;
    end
    chk($sformatf("digit_%b_seen", an_exp), 16'(seen), 16'd1);
    chk($sformatf("digit_%b_seg", an_exp), 16'(seg), 16'(seg_exp));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; data = '0; dp_en = '0; digit_en = 4'hF; lz_supp = 1'b0; blank = 1'b0;

    // 1: reset and first frame
    for (int i = 0; i < 3; i++) step();
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_seg", 16'(seg), 16'h00FF);
    chk("rst_ft", 16'(frame_tick), 16'h0);
    rst = 1'b0;
    step();
    chk("first_ft", 16'(frame_tick), 16'h1);
    chk("first_blank_an", 16'(an), 16'h000F);
    step();
    chk("d0_an", 16'(an), 16'h000E);
    chk("d0_seg", 16'(seg), 16'h00C0);

    // 2: plain hex scan and frame period
    data = 16'h12AF;
    wait_frame();
    expect_digit(4'b1110, 8'h8E);
    expect_digit(4'b1101, 8'h88);
    expect_digit(4'b1011, 8'hA4);
    expect_digit(4'b0111, 8'hF9);
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt++;
      if (frame_tick === 1'b1) break;
    end
    chk("frame_period", 16'(cnt), 16'd16);

    // 3: leading-zero suppression with DP
    data = 16'h0050; lz_supp = 1'b1; dp_en = 4'b0100;
    wait_frame();
    expect_digit(4'b1110, 8'hC0);
    expect_digit(4'b1101, 8'h92);
    expect_digit(4'b1011, 8'h7F);
    expect_digit(4'b0111, 8'hFF);
    data = 16'h0000; dp_en = 4'b0000;
    wait_frame();
    expect_digit(4'b1110, 8'hC0);
    expect_digit(4'b1101, 8'hFF);
    expect_digit(4'b1011, 8'hFF);
    expect_digit(4'b0111, 8'hFF);

    // 4: data change mid-frame is held off until the next snapshot
    lz_supp = 1'b0; data = 16'h1111;
    wait_frame();
    expect_digit(4'b1110, 8'hF9);
    expect_digit(4'b1101, 8'hF9);
    for (int i = 0; i < 40 && m_idx != 2; i++) step();
    data = 16'h2222;
    expect_digit(4'b1011, 8'hF9);
    expect_digit(4'b0111, 8'hF9);
    wait_frame();
    expect_digit(4'b1110, 8'hA4);
    expect_digit(4'b1101, 8'hA4);
    expect_digit(4'b1011, 8'hA4);
    expect_digit(4'b0111, 8'hA4);

    // 5: digit mask and live blank
    data = 16'h1111; digit_en = 4'b0101;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an === 4'b1101 || an === 4'b0111) cnt++;
    end
    chk("masked_digits_dark", 16'(cnt), 16'd0);
    blank = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an !== 4'hF) cnt++;
    end
    chk("blank_dark", 16'(cnt), 16'd0);
    blank = 1'b0;
    for (int i = 0; i < 16; i++) step();

    // 6: reset mid-scan restarts at digit 0 with a fresh snapshot
    digit_en = 4'hF;
    for (int i = 0; i < 40 && !(m_idx == 3 && m_presc == 2); i++) step();
    rst = 1'b1;
    step();
    chk("midrst_an", 16'(an), 16'h000F);
    chk("midrst_seg", 16'(seg), 16'h00FF);
    rst = 1'b0;
    step();
    chk("midrst_ft", 16'(frame_tick), 16'h1);
    expect_digit(4'b1110, 8'hF9);
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
